// File: rtl/xtsc_inq_packer.sv
// xtsc_inq_packer: packs BEATS input beats per word into a FIFO feeding a TIE_INQ1 pop port; optional XTSC_INQ_STATS_EN adds PopCount/StallCount
module xtsc_inq_packer #(
  parameter int BEAT_W = 32,
  parameter int BEATS  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      Flush,
  input  logic                      S_Valid,
  input  logic [BEAT_W-1:0]         S_Data,
  output logic                      S_Ready,
  input  logic                      TIE_INQ1_PopReq,
  output logic [BEAT_W*BEATS-1:0]   TIE_INQ1,
  output logic                      TIE_INQ1_Empty
`ifdef XTSC_INQ_STATS_EN
  ,
  output logic [31:0]               PopCount,
  output logic [31:0]               StallCount
`endif
);
  localparam int DATA_W = BEAT_W * BEATS;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [CW-1:0]     beat_cnt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic [DATA_W-1:0] stage, word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              last, acc, push, pop;
  assign last    = beat_cnt == CW'(BEATS - 1);
  assign S_Ready = !(last && count == (AW+1)'(DEPTH));
  assign acc     = S_Valid && S_Ready && !Flush;
  assign push    = acc && last;
  assign pop     = TIE_INQ1_PopReq && !TIE_INQ1_Empty && !Flush;
  // Completed word: staged beats with the final beat placed directly in the top slot
  always_comb begin
    word = stage;
    word[DATA_W-1 -: BEAT_W] = S_Data;
  end
  // Next occupancy; a same-cycle push and pop cancel out
  always_comb count_nxt = Flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  // Beat counter and staging register; each beat overwrites its own slot so no stale bits leak
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      beat_cnt <= '0;
      stage    <= '0;
    end else if (Flush) begin
      beat_cnt <= '0;
    end else if (acc) begin
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      for (int k = 0; k < BEATS; k++)
        if (beat_cnt == CW'(k)) stage[k*BEAT_W +: BEAT_W] <= S_Data;
    end
  // FIFO pointers, occupancy and registered empty flag
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      TIE_INQ1_Empty <= 1'b1;
    end else begin
      wr_ptr         <= Flush ? '0 : wr_ptr + AW'(push);
      rd_ptr         <= Flush ? '0 : rd_ptr + AW'(pop);
      count          <= count_nxt;
      TIE_INQ1_Empty <= count_nxt == '0;
    end
  // Output word: loaded on an accepted pop, held otherwise (including across Flush)
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) TIE_INQ1 <= '0;
    else if (pop) TIE_INQ1 <= mem[rd_ptr];
  // Word storage; contents are only visible through count, so no reset is needed
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= word;
`ifdef XTSC_INQ_STATS_EN
  // Pop counter wraps, stall counter saturates; both cleared with the queue
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      PopCount   <= '0;
      StallCount <= '0;
    end else if (Flush) begin
      PopCount   <= '0;
      StallCount <= '0;
    end else begin
      if (pop) PopCount <= PopCount + 32'd1;
      if (TIE_INQ1_PopReq && TIE_INQ1_Empty && StallCount != '1) StallCount <= StallCount + 32'd1;
    end
`endif
endmodule
